// File: rtl/wb_regfile.sv
// Write-back stage merged with the 32-entry register file: selects WB data, commits it on the
// clock edge and serves two combinational read ports with same-cycle write-to-read bypass.
module wb_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memToReg_MEM_WB,
  input  logic              regWrite_MEM_WB,
  input  logic [ADDR_W-1:0] destReg_MEM_WB,
  input  logic [DATA_W-1:0] memData_MEM_WB,
  input  logic [DATA_W-1:0] aluOut_MEM_WB,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wbData,
  output logic [31:0]       wrCount
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [31:0]       r_wr_count;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wr_en;

  assign w_wb_data = memToReg_MEM_WB ? memData_MEM_WB : aluOut_MEM_WB;
  // Writes to $0 are neither stored nor counted.
  assign w_wr_en   = regWrite_MEM_WB && (destReg_MEM_WB != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_wr_en) begin
      r_regs[destReg_MEM_WB] <= w_wb_data;
      r_wr_count             <= r_wr_count + 32'd1;
    end
  end

  always_comb begin
    rs_data = r_regs[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (BYPASS && w_wr_en && (rs_addr == destReg_MEM_WB)) begin
      rs_data = w_wb_data;
    end
  end

  always_comb begin
    rt_data = r_regs[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (BYPASS && w_wr_en && (rt_addr == destReg_MEM_WB)) begin
      rt_data = w_wb_data;
    end
  end

  assign wbData  = w_wb_data;
  assign wrCount = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vectors, an array/counter model checked every negedge, and
// hand-computed literal expectations at key points.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memToReg_MEM_WB = 1'b0;
  logic        regWrite_MEM_WB = 1'b0;
  logic [4:0]  destReg_MEM_WB = '0;
  logic [31:0] memData_MEM_WB = '0;
  logic [31:0] aluOut_MEM_WB = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data, rt_data, wbData, wrCount;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;

  wb_regfile dut (
    .clk             (clk),
    .reset           (reset),
    .memToReg_MEM_WB (memToReg_MEM_WB),
    .regWrite_MEM_WB (regWrite_MEM_WB),
    .destReg_MEM_WB  (destReg_MEM_WB),
    .memData_MEM_WB  (memData_MEM_WB),
    .aluOut_MEM_WB   (aluOut_MEM_WB),
    .rs_addr         (rs_addr),
    .rt_addr         (rt_addr),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .wbData          (wbData),
    .wrCount         (wrCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a plain array of architectural values plus a write counter.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_count <= '0;
    end else if (regWrite_MEM_WB && destReg_MEM_WB != 0) begin
      m_regs[destReg_MEM_WB] <= memToReg_MEM_WB ? memData_MEM_WB : aluOut_MEM_WB;
      m_count <= m_count + 1;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (regWrite_MEM_WB && destReg_MEM_WB == a)
      return memToReg_MEM_WB ? memData_MEM_WB : aluOut_MEM_WB;
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rs", rs_data, exp_read(rs_addr));
      check("cyc_rt", rt_data, exp_read(rt_addr));
      check("cyc_wb", wbData, memToReg_MEM_WB ? memData_MEM_WB : aluOut_MEM_WB);
      check("cyc_cnt", wrCount, m_count);
    end
  end

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] d, input logic m2r, input logic [31:0] mem,
                         input logic [31:0] alu);
    regWrite_MEM_WB = 1'b1;
    destReg_MEM_WB  = d;
    memToReg_MEM_WB = m2r;
    memData_MEM_WB  = mem;
    aluOut_MEM_WB   = alu;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    rs_addr = a;
    rt_addr = a;
    #1;
    check({name, "_rs"}, rs_data, exp);
    check({name, "_rt"}, rt_data, exp);
  endtask

  initial begin
    next_cyc();
    next_cyc();
    reset = 1'b0;
    chk_en = 1'b1;

    // ALU write to reg 5
    present(5'd5, 1'b0, 32'h0, 32'h1234_5678);
    next_cyc();
    regWrite_MEM_WB = 1'b0;
    rd("alu_wr", 5'd5, 32'h1234_5678);
    check("alu_cnt", wrCount, 32'd1);

    // Load write to reg 9
    next_cyc();
    present(5'd9, 1'b1, 32'hDEAD_BEEF, 32'h1);
    #1 check("ld_wbdata", wbData, 32'hDEAD_BEEF);
    next_cyc();
    regWrite_MEM_WB = 1'b0;
    rd("ld_wr", 5'd9, 32'hDEAD_BEEF);
    check("ld_cnt", wrCount, 32'd2);

    // $0 protection
    next_cyc();
    present(5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    rd("r0_pre", 5'd0, 32'h0);
    next_cyc();
    regWrite_MEM_WB = 1'b0;
    rd("r0_post", 5'd0, 32'h0);
    check("r0_cnt", wrCount, 32'd2);

    // Bypass on both ports at once
    next_cyc();
    present(5'd7, 1'b0, 32'h0, 32'hA);
    next_cyc();
    present(5'd7, 1'b0, 32'h0, 32'hB);
    rd("byp_pre", 5'd7, 32'hB);
    next_cyc();
    regWrite_MEM_WB = 1'b0;
    rd("byp_post", 5'd7, 32'hB);
    check("byp_cnt", wrCount, 32'd4);

    // Disabled write leaves state alone
    next_cyc();
    present(5'd3, 1'b0, 32'h0, 32'h55);
    regWrite_MEM_WB = 1'b0;
    rd("dis_pre", 5'd3, 32'h0);
    next_cyc();
    rd("dis_post", 5'd3, 32'h0);
    check("dis_cnt", wrCount, 32'd4);

    // Fill every register, reading back through both ports with different addresses
    for (int i = 1; i < 32; i++) begin
      next_cyc();
      present(5'(i), 1'(i % 2), 32'h0101_0101 * i, ~(32'h0101_0101 * i));
    end
    next_cyc();
    regWrite_MEM_WB = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      next_cyc();
    end
    rd("fill_r4", 5'd4, ~32'h0404_0404);
    rd("fill_r31", 5'd31, 32'h1F1F_1F1F);
    check("fill_cnt", wrCount, 32'd35);

    // Reset mid-cycle while a valid write to reg 4 is presented
    next_cyc();
    rs_addr = 5'd5;
    rt_addr = 5'd9;
    present(5'd4, 1'b0, 32'h0, 32'h44);
    #1 reset = 1'b1;
    #1;
    check("rst_cnt_now", wrCount, 32'd0);
    check("rst_r5_now", rs_data, 32'h0);
    check("rst_r9_now", rt_data, 32'h0);
    next_cyc();
    regWrite_MEM_WB = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(i);
      #0.1;
      check("rst_sweep_rs", rs_data, 32'h0);
      check("rst_sweep_rt", rt_data, 32'h0);
    end
    next_cyc();
    reset = 1'b0;
    next_cyc();
    rd("rst_abort_r4", 5'd4, 32'h0);
    check("rst_abort_cnt", wrCount, 32'd0);

    // Counting resumes cleanly after reset
    next_cyc();
    present(5'd4, 1'b1, 32'hCAFE_F00D, 32'h0);
    next_cyc();
    regWrite_MEM_WB = 1'b0;
    rd("post_rst_r4", 5'd4, 32'hCAFE_F00D);
    check("post_rst_cnt", wrCount, 32'd1);
    next_cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
